// File: rtl/pipe_datapath_hzd_if.sv
// Issue, data-memory and writeback bundle of pipe_datapath_hzd.
// The master is the instruction source and data memory; the slave is the datapath.
interface pipe_datapath_hzd_if #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [RADDR_W-1:0] in_rs;
  logic [RADDR_W-1:0] in_rt;
  logic [RADDR_W-1:0] in_rd;
  logic [15:0]        in_imm;
  logic               RegDst;
  logic               RegWr;
  logic               ALUsrc;
  logic [1:0]         ALUcntrl;
  logic               MemWr;
  logic               MemToReg;
  logic [WIDTH-1:0]   dmem_addr;
  logic [WIDTH-1:0]   dmem_wdata;
  logic               dmem_we;
  logic [WIDTH-1:0]   dmem_rdata;
  logic [WIDTH-1:0]   reg_Da;
  logic [WIDTH-1:0]   seOut;
  logic               wb_valid;
  logic [RADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]   wb_data;

  modport master (
    output in_valid, in_rs, in_rt, in_rd, in_imm, RegDst, RegWr, ALUsrc, ALUcntrl,
           MemWr, MemToReg, dmem_rdata,
    input  in_ready, dmem_addr, dmem_wdata, dmem_we, reg_Da, seOut, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_rd, in_imm, RegDst, RegWr, ALUsrc, ALUcntrl,
           MemWr, MemToReg, dmem_rdata,
    output in_ready, dmem_addr, dmem_wdata, dmem_we, reg_Da, seOut, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/pipe_datapath_hzd.sv
// ID/EX/MEM/WB integer datapath with internal regfile, EX/MEM forwarding into ID
// and load-use / no-forward stall generation towards the issue side.
module pipe_datapath_hzd #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5,
  parameter int FWD_EN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  pipe_datapath_hzd_if.slave bus
);
  localparam int NREG = 2 ** RADDR_W;
  localparam bit FWD  = (FWD_EN != 0);

  typedef logic        [RADDR_W-1:0] ra_t;
  typedef logic signed [WIDTH-1:0]   word_t;

  function automatic word_t sext_f(input logic [15:0] imm);
    logic signed [15:0] s;
    s = imm;
    return WIDTH'(s);
  endfunction

  function automatic word_t alu_f(input word_t a, input word_t b, input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  word_t rf_q [NREG];

  logic        vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;
  ra_t         rs_p0_q, rt_p0_q, rd_p0_q;
  logic [15:0] imm_p0_q;
  logic        regdst_p0_q, regwr_p0_q, alusrc_p0_q, memwr_p0_q, memtoreg_p0_q;
  logic [1:0]  aluc_p0_q;

  word_t       a_p1_q, b_p1_q, imm_p1_q;
  ra_t         dst_p1_q;
  logic        regwr_p1_q, alusrc_p1_q, memwr_p1_q, memtoreg_p1_q;
  logic [1:0]  aluc_p1_q;

  word_t       alu_p2_q, sd_p2_q;
  ra_t         dst_p2_q;
  logic        regwr_p2_q, memwr_p2_q, memtoreg_p2_q;

  ra_t         dst_p3_q;
  word_t       data_p3_q;

  ra_t         dst_p0;
  logic        uses_rt_p0;
  word_t       alu_p1, wbd_p2;
  logic        wr_p1, wr_p2;
  logic        ma_p1, mb_p1, ma_p2, mb_p2;
  logic        need_p1, need_p2, stall;
  word_t       opa_p0_d, opb_p0_d;

  // Regfile read with same-cycle bypass of the value being written back
  function automatic word_t rf_read_f(input ra_t a);
    if (a == '0)
      return '0;
    if (vld_p3_q && (dst_p3_q == a))
      return data_p3_q;
    return rf_q[a];
  endfunction

  assign dst_p0     = regdst_p0_q ? rd_p0_q : rt_p0_q;
  assign uses_rt_p0 = !alusrc_p0_q | memwr_p0_q;

  assign alu_p1 = alu_f(a_p1_q, alusrc_p1_q ? imm_p1_q : b_p1_q, aluc_p1_q);
  assign wbd_p2 = memtoreg_p2_q ? $signed(bus.dmem_rdata) : alu_p2_q;

  assign wr_p1 = vld_p1_q & regwr_p1_q & (dst_p1_q != '0);
  assign wr_p2 = vld_p2_q & regwr_p2_q & (dst_p2_q != '0);
  assign ma_p1 = wr_p1 & (dst_p1_q == rs_p0_q);
  assign mb_p1 = wr_p1 & (dst_p1_q == rt_p0_q);
  assign ma_p2 = wr_p2 & (dst_p2_q == rs_p0_q);
  assign mb_p2 = wr_p2 & (dst_p2_q == rt_p0_q);

  always_comb begin
    need_p1 = ma_p1 | (uses_rt_p0 & mb_p1);
    need_p2 = ma_p2 | (uses_rt_p0 & mb_p2);
    if (FWD)
      stall = vld_p0_q & memtoreg_p1_q & need_p1;
    else
      stall = vld_p0_q & (need_p1 | need_p2);
  end

  // A load in EX has no result yet, so it never feeds the EX forward path
  always_comb begin
    opa_p0_d = rf_read_f(rs_p0_q);
    opb_p0_d = rf_read_f(rt_p0_q);
    if (FWD) begin
      if (ma_p1 && !memtoreg_p1_q) opa_p0_d = alu_p1;
      else if (ma_p2)              opa_p0_d = wbd_p2;
      if (mb_p1 && !memtoreg_p1_q) opb_p0_d = alu_p1;
      else if (mb_p2)              opb_p0_d = wbd_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (!stall) vld_p0_q <= bus.in_valid;
      vld_p1_q <= vld_p0_q & !stall;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= wr_p2;
      if (vld_p3_q) rf_q[dst_p3_q] <= data_p3_q;
    end
  end

  always_ff @(posedge clk) begin
    // input -> ID
    if (!stall) begin
      rs_p0_q       <= bus.in_rs;
      rt_p0_q       <= bus.in_rt;
      rd_p0_q       <= bus.in_rd;
      imm_p0_q      <= bus.in_imm;
      regdst_p0_q   <= bus.RegDst;
      regwr_p0_q    <= bus.RegWr;
      alusrc_p0_q   <= bus.ALUsrc;
      aluc_p0_q     <= bus.ALUcntrl;
      memwr_p0_q    <= bus.MemWr;
      memtoreg_p0_q <= bus.MemToReg;
    end
    // ID -> EX
    a_p1_q        <= opa_p0_d;
    b_p1_q        <= opb_p0_d;
    imm_p1_q      <= sext_f(imm_p0_q);
    dst_p1_q      <= dst_p0;
    regwr_p1_q    <= regwr_p0_q;
    alusrc_p1_q   <= alusrc_p0_q;
    aluc_p1_q     <= aluc_p0_q;
    memwr_p1_q    <= memwr_p0_q;
    memtoreg_p1_q <= memtoreg_p0_q;
    // EX -> MEM
    alu_p2_q      <= alu_p1;
    sd_p2_q       <= b_p1_q;
    dst_p2_q      <= dst_p1_q;
    regwr_p2_q    <= regwr_p1_q;
    memwr_p2_q    <= memwr_p1_q;
    memtoreg_p2_q <= memtoreg_p1_q;
    // MEM -> WB
    dst_p3_q      <= dst_p2_q;
    data_p3_q     <= wbd_p2;
  end

  assign bus.in_ready   = !stall;
  assign bus.reg_Da     = vld_p1_q ? a_p1_q : '0;
  assign bus.seOut      = vld_p1_q ? imm_p1_q : '0;
  assign bus.dmem_we    = vld_p2_q & memwr_p2_q;
  assign bus.dmem_addr  = vld_p2_q ? alu_p2_q : '0;
  assign bus.dmem_wdata = vld_p2_q ? sd_p2_q : '0;
  assign bus.wb_valid   = vld_p3_q;
  assign bus.wb_addr    = vld_p3_q ? dst_p3_q : '0;
  assign bus.wb_data    = vld_p3_q ? data_p3_q : '0;
endmodule

// File: tb/tb_pipe_datapath_hzd.sv
// Directed bench for pipe_datapath_hzd: one forwarding and one stall-only instance
// share the stimulus; sel routes in_valid and the observed outputs.
module tb_pipe_datapath_hzd;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  s_rs = '0, s_rt = '0, s_rd = '0;
  logic [15:0] s_imm = '0;
  logic        s_regdst = 1'b0, s_regwr = 1'b0, s_alusrc = 1'b0, s_memwr = 1'b0, s_m2r = 1'b0;
  logic [1:0]  s_op = '0;
  logic [31:0] rdata = '0;

  pipe_datapath_hzd_if #(.WIDTH(32), .RADDR_W(5)) bf ();
  pipe_datapath_hzd_if #(.WIDTH(32), .RADDR_W(5)) bn ();

  assign bf.in_valid = in_valid & sel;
  assign bn.in_valid = in_valid & ~sel;
  assign bf.in_rs = s_rs;       assign bn.in_rs = s_rs;
  assign bf.in_rt = s_rt;       assign bn.in_rt = s_rt;
  assign bf.in_rd = s_rd;       assign bn.in_rd = s_rd;
  assign bf.in_imm = s_imm;     assign bn.in_imm = s_imm;
  assign bf.RegDst = s_regdst;  assign bn.RegDst = s_regdst;
  assign bf.RegWr = s_regwr;    assign bn.RegWr = s_regwr;
  assign bf.ALUsrc = s_alusrc;  assign bn.ALUsrc = s_alusrc;
  assign bf.ALUcntrl = s_op;    assign bn.ALUcntrl = s_op;
  assign bf.MemWr = s_memwr;    assign bn.MemWr = s_memwr;
  assign bf.MemToReg = s_m2r;   assign bn.MemToReg = s_m2r;
  assign bf.dmem_rdata = rdata; assign bn.dmem_rdata = rdata;

  pipe_datapath_hzd #(.WIDTH(32), .RADDR_W(5), .FWD_EN(1)) u_dut (.clk(clk), .rst(rst), .bus(bf));
  pipe_datapath_hzd #(.WIDTH(32), .RADDR_W(5), .FWD_EN(0)) u_dut_nf (.clk(clk), .rst(rst), .bus(bn));

  logic        o_ready, o_we, o_wbv;
  logic [31:0] o_addr, o_wdata, o_da, o_se, o_wbd;
  logic [4:0]  o_wba;
  assign o_ready = sel ? bf.in_ready   : bn.in_ready;
  assign o_we    = sel ? bf.dmem_we    : bn.dmem_we;
  assign o_wbv   = sel ? bf.wb_valid   : bn.wb_valid;
  assign o_addr  = sel ? bf.dmem_addr  : bn.dmem_addr;
  assign o_wdata = sel ? bf.dmem_wdata : bn.dmem_wdata;
  assign o_da    = sel ? bf.reg_Da     : bn.reg_Da;
  assign o_se    = sel ? bf.seOut      : bn.seOut;
  assign o_wbd   = sel ? bf.wb_data    : bn.wb_data;
  assign o_wba   = sel ? bf.wb_addr    : bn.wb_addr;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int nrdy     = 0;
  logic [4:0]  wq_a[$];
  logic [31:0] wq_d[$];
  int          wq_c[$];
  logic [31:0] mq_a[$];
  logic [31:0] mq_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_wbv) begin
      wq_a.push_back(o_wba);
      wq_d.push_back(o_wbd);
      wq_c.push_back(cyc);
    end
    if (o_we) begin
      mq_a.push_back(o_addr);
      mq_d.push_back(o_wdata);
    end
    if (!o_ready) nrdy = nrdy + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    mq_a.delete(); mq_d.delete();
    nrdy = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm, input logic regdst, input logic regwr,
                       input logic alusrc, input logic [1:0] op, input logic memwr,
                       input logic m2r);
    int n;
    s_rs = rs; s_rt = rt; s_rd = rd; s_imm = imm;
    s_regdst = regdst; s_regwr = regwr; s_alusrc = alusrc; s_op = op;
    s_memwr = memwr; s_m2r = m2r;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) check_eq("issue_timeout", {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic addi(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    issue(rs, rt, 5'd0, imm, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic rop(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [15:0] imm);
    issue(rs, rt, rd, imm, 1'b1, 1'b1, 1'b0, op, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state and idle
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, o_ready}, 32'd1);
    check_eq("rst_wbv", {31'd0, o_wbv}, 32'd0);
    check_eq("rst_we", {31'd0, o_we}, 32'd0);
    check_eq("rst_addr", o_addr, 32'd0);
    check_eq("rst_wbd", o_wbd, 32'd0);
    check_eq("rst_da", o_da, 32'd0);
    rst = 1'b0;
    clear_logs();
    idle(5);
    check_eq("idle_wb_cnt", wq_a.size(), 32'd0);
    check_eq("idle_we_cnt", mq_a.size(), 32'd0);

    // forwarding: addi r1,r0,5 ; add r2,r1,r1
    clear_logs();
    addi(5'd1, 5'd0, 16'd5);
    rop(2'b00, 5'd2, 5'd1, 5'd1, 16'hFFF0);
    @(negedge clk);
    @(negedge clk);
    check_eq("fwd_regDa", o_da, 32'd5);
    check_eq("fwd_seOut", o_se, 32'hFFFF_FFF0);
    idle(6);
    check_eq("fwd_stalls", nrdy, 32'd0);
    check_eq("fwd_wb_cnt", wq_a.size(), 32'd2);
    check_eq("fwd_wb0_addr", {27'd0, wq_a[0]}, 32'd1);
    check_eq("fwd_wb0_data", wq_d[0], 32'd5);
    check_eq("fwd_wb1_addr", {27'd0, wq_a[1]}, 32'd2);
    check_eq("fwd_wb1_data", wq_d[1], 32'd10);
    check_eq("fwd_wb_gap", wq_c[1] - wq_c[0], 32'd1);

    // load-use: lw r3,0(r0) ; add r4,r3,r3
    clear_logs();
    rdata = 32'h0000_1234;
    issue(5'd0, 5'd3, 5'd0, 16'd0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    rop(2'b00, 5'd4, 5'd3, 5'd3, 16'd0);
    idle(8);
    check_eq("lu_stalls", nrdy, 32'd1);
    check_eq("lu_wb_cnt", wq_a.size(), 32'd2);
    check_eq("lu_wb0_data", wq_d[0], 32'h0000_1234);
    check_eq("lu_wb1_addr", {27'd0, wq_a[1]}, 32'd4);
    check_eq("lu_wb1_data", wq_d[1], 32'h0000_2468);

    // stall-only instance: same pair as the forwarding test
    sel = 1'b0;
    #1;
    clear_logs();
    addi(5'd1, 5'd0, 16'd5);
    rop(2'b00, 5'd2, 5'd1, 5'd1, 16'd0);
    idle(10);
    check_eq("nf_stalls", nrdy, 32'd2);
    check_eq("nf_wb_cnt", wq_a.size(), 32'd2);
    check_eq("nf_wb0_data", wq_d[0], 32'd5);
    check_eq("nf_wb1_addr", {27'd0, wq_a[1]}, 32'd2);
    check_eq("nf_wb1_data", wq_d[1], 32'd10);

    // r0 write dropped, sub wrap, store
    sel = 1'b1;
    #1;
    clear_logs();
    addi(5'd0, 5'd0, 16'd7);
    addi(5'd6, 5'd0, 16'd1);
    rop(2'b01, 5'd5, 5'd0, 5'd6, 16'd0);
    issue(5'd0, 5'd5, 5'd0, 16'd4, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
    idle(8);
    check_eq("r0_wb_cnt", wq_a.size(), 32'd2);
    check_eq("sub_wb_addr", {27'd0, wq_a[1]}, 32'd5);
    check_eq("sub_wb_data", wq_d[1], 32'hFFFF_FFFF);
    check_eq("sw_we_cnt", mq_a.size(), 32'd1);
    check_eq("sw_addr", mq_a[0], 32'd4);
    check_eq("sw_wdata", mq_d[0], 32'hFFFF_FFFF);

    // reset squashes in-flight writes and clears the regfile
    clear_logs();
    addi(5'd1, 5'd0, 16'd11);
    addi(5'd2, 5'd0, 16'd12);
    addi(5'd3, 5'd0, 16'd13);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(8);
    check_eq("sq_wb_cnt", wq_a.size(), 32'd0);
    check_eq("sq_we_cnt", mq_a.size(), 32'd0);
    rop(2'b11, 5'd8, 5'd1, 5'd1, 16'd0);
    rop(2'b11, 5'd8, 5'd2, 5'd2, 16'd0);
    rop(2'b11, 5'd8, 5'd3, 5'd3, 16'd0);
    idle(8);
    check_eq("rd_wb_cnt", wq_a.size(), 32'd3);
    check_eq("rd_r1", wq_d[0], 32'd0);
    check_eq("rd_r2", wq_d[1], 32'd0);
    check_eq("rd_r3", wq_d[2], 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
